// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter_if
// Brief   : Requester-side and FIFO-write-side signals of fifo_wr_arbiter.
// Revision: 1.0
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    // Master drives requests and the FIFO full flag; the arbiter is the slave.
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Round-robin burst arbiter feeding one FIFO write port.
//           Define FIFO_WR_ARB_CNT_EN to add the 16-bit beat_count output.
// Revision: 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  wire logic          clk,
    input  wire logic          wrst_n,
`ifdef FIFO_WR_ARB_CNT_EN
    output logic [15:0]        beat_count,
`endif
    fifo_wr_arbiter_if.slave   arb
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q;
    logic [ID_W-1:0]    owner_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic [2*NUM_REQ-1:0]  rot_valid;
    logic                  pick_valid;
    logic [ID_W-1:0]       pick_id;
    logic [ID_W-1:0]       rr_ptr_d;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [NUM_REQ-1:0]    ready;
    logic                  xfer;
    int                    pick_off;
    int                    pick_sum;

    // Rotating the doubled valid vector puts rr_ptr at bit 0, so the
    // lowest set bit is the round-robin winner's offset from rr_ptr.
    always_comb begin
        rot_valid  = {arb.req_valid, arb.req_valid} >> rr_ptr_q;
        pick_valid = 1'b0;
        pick_off   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_valid && rot_valid[i]) begin
                pick_valid = 1'b1;
                pick_off   = i;
            end
        end
        pick_sum = int'(rr_ptr_q) + pick_off;
        if (pick_sum >= NUM_REQ) begin
            pick_sum = pick_sum - NUM_REQ;
        end
        pick_id  = ID_W'(pick_sum);
        rr_ptr_d = (pick_id == LAST_ID) ? '0 : pick_id + ID_W'(1);
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        ready       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_valid = arb.req_valid[i];
                owner_data  = arb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                ready[i]    = (state_q == GRANT) && !arb.fifo_full;
            end
        end
    end

    assign xfer             = (state_q == GRANT) && owner_valid && !arb.fifo_full;
    assign arb.req_ready    = ready;
    assign arb.fifo_w_en    = xfer;
    assign arb.fifo_data_in = (state_q == GRANT) ? owner_data : '0;
    assign arb.grant_id     = owner_q;
    assign arb.busy         = (state_q == GRANT);

    always_ff @(posedge clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q    <= pick_id;
                        rr_ptr_q   <= rr_ptr_d;
                        beat_cnt_q <= '0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    // A full FIFO holds both the grant and the beat count.
                    if (!owner_valid) begin
                        state_q <= IDLE;
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_CNT_EN
    logic [15:0] beat_count_q;

    always_ff @(posedge clk or negedge wrst_n) begin
        if (!wrst_n) begin
            beat_count_q <= '0;
        end else if (xfer) begin
            beat_count_q <= beat_count_q + 16'd1;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_wr_arbiter
// Brief   : Directed self-checking bench for fifo_wr_arbiter.
// Revision: 1.0
// ============================================================================
module tb_fifo_wr_arbiter;
    logic clk;
    logic wrst_n;
    int   tests;
    int   fails;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) if0 ();
    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) if1 ();

`ifdef FIFO_WR_ARB_CNT_EN
    logic [15:0] bc0;
    logic [15:0] bc1;
`endif

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut0 (
        .clk    (clk),
        .wrst_n (wrst_n),
`ifdef FIFO_WR_ARB_CNT_EN
        .beat_count (bc0),
`endif
        .arb    (if0.slave)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut1 (
        .clk    (clk),
        .wrst_n (wrst_n),
`ifdef FIFO_WR_ARB_CNT_EN
        .beat_count (bc1),
`endif
        .arb    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One burst from requester id on dut0; bit c of each mask is cycle c.
    task automatic run(input string tag, input int id, input logic [7:0] base,
                       input int nbeats, input int ncyc,
                       input logic [31:0] wen_e, input logic [31:0] busy_e,
                       input logic [31:0] full_p);
        int k;
        k = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if0.req_valid = (k < nbeats) ? (4'b0001 << id) : 4'b0000;
            if0.req_data  = '0;
            if0.req_data[id*8 +: 8] = base + 8'(k);
            if0.fifo_full = full_p[c];
            #4;
            chk($sformatf("%s w_en c%0d", tag, c), 32'(if0.fifo_w_en), 32'(wen_e[c]));
            chk($sformatf("%s busy c%0d", tag, c), 32'(if0.busy), 32'(busy_e[c]));
            if (wen_e[c]) begin
                chk($sformatf("%s data c%0d", tag, c), 32'(if0.fifo_data_in), 32'(base + 8'(k)));
                chk($sformatf("%s gid c%0d", tag, c), 32'(if0.grant_id), 32'(id));
                chk($sformatf("%s ready c%0d", tag, c), 32'(if0.req_ready), 32'(4'b0001 << id));
                k++;
            end else if (full_p[c]) begin
                chk($sformatf("%s ready_full c%0d", tag, c), 32'(if0.req_ready), 32'h0);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        wrst_n = 1'b0;
        if0.req_valid = '0; if0.req_data = '0; if0.fifo_full = 1'b0;
        if1.req_valid = '0; if1.req_data = '0; if1.fifo_full = 1'b0;

        #12;
        chk("rst ready", 32'(if0.req_ready), 32'h0);
        chk("rst w_en", 32'(if0.fifo_w_en), 32'h0);
        chk("rst data", 32'(if0.fifo_data_in), 32'h0);
        chk("rst gid", 32'(if0.grant_id), 32'h0);
        chk("rst busy", 32'(if0.busy), 32'h0);
        @(posedge clk); #1 wrst_n = 1'b1;

        // Single requester, 3 beats: grant after one cycle, then idle.
        run("single", 0, 8'hA1, 3, 6, 32'h0E, 32'h1E, 32'h0);
        @(posedge clk); #1;
        chk("single idle data", 32'(if0.fifo_data_in), 32'h0);

        // Burst cap of 4 with one idle cycle between re-grants.
        run("cap", 2, 8'hC0, 10, 15, 32'h1BDE, 32'h3BDE, 32'h0);

        // Backpressure: five full cycles after two beats.
        run("bp", 1, 8'h50, 4, 11, 32'h306, 32'h3FE, 32'hF8);

        // Reset during the second beat of requester 2 (rr_ptr is 2 here).
        @(posedge clk); #1;
        if0.req_valid = 4'b0100; if0.req_data = '0; if0.req_data[23:16] = 8'h70;
        #4 chk("rmb idle", 32'(if0.busy), 32'h0);
        @(posedge clk); #4 chk("rmb beat0", 32'(if0.fifo_w_en), 32'h1);
        @(posedge clk); #1 if0.req_data[23:16] = 8'h71;
        #4 chk("rmb beat1 data", 32'(if0.fifo_data_in), 32'h71);
        #1 wrst_n = 1'b0;
        #1;
        chk("rmb ready", 32'(if0.req_ready), 32'h0);
        chk("rmb w_en", 32'(if0.fifo_w_en), 32'h0);
        chk("rmb data", 32'(if0.fifo_data_in), 32'h0);
        chk("rmb gid", 32'(if0.grant_id), 32'h0);
        chk("rmb busy", 32'(if0.busy), 32'h0);
        @(posedge clk); #4 chk("rmb w_en held", 32'(if0.fifo_w_en), 32'h0);
        @(posedge clk); #1;
        wrst_n = 1'b1;
        if0.req_valid = 4'b1100; if0.req_data = {8'h93, 8'h92, 8'h00, 8'h00};
        #4;
        chk("rmb post idle", 32'(if0.busy), 32'h0);
        chk("rmb post gid0", 32'(if0.grant_id), 32'h0);
        @(posedge clk); #4;
        chk("rmb regrant busy", 32'(if0.busy), 32'h1);
        chk("rmb regrant gid", 32'(if0.grant_id), 32'h2);
        chk("rmb regrant data", 32'(if0.fifo_data_in), 32'h92);
        @(posedge clk); #1 if0.req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #4 chk("rmb end idle", 32'(if0.busy), 32'h0);

        // Fairness on the MAX_BURST=1 instance with all requesters valid.
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1 if1.req_valid = 4'b1111;
            #4;
            chk($sformatf("fair busy c%0d", c), 32'(if1.busy), 32'(c % 2));
            if (c % 2 == 1) begin
                chk($sformatf("fair gid c%0d", c), 32'(if1.grant_id), 32'(((c - 1) / 2) % 4));
                chk($sformatf("fair w_en c%0d", c), 32'(if1.fifo_w_en), 32'h1);
            end
        end
        @(posedge clk); #1 if1.req_valid = '0;

`ifdef FIFO_WR_ARB_CNT_EN
        begin
            int seen;
            int cyc;
            seen = 0;
            cyc  = 0;
            #1 wrst_n = 1'b0;
            #1 chk("cnt rst", 32'(bc0), 32'h0);
            @(posedge clk); #1 wrst_n = 1'b1;
            if0.req_valid = 4'b0001;
            while (seen < 70000 && cyc < 95000) begin
                @(negedge clk);
                if (if0.fifo_w_en) seen++;
                cyc++;
            end
            @(posedge clk); #1 if0.req_valid = '0;
            @(posedge clk); #1;
            chk("cnt transfers", 32'(seen), 32'd70000);
            chk("cnt wrap", 32'(bc0), 32'd4464);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
